// File: rtl/master_if_pkg.sv
// Shared defaults and helpers for the prefetching master-side bridge.
package master_if_pkg;

    localparam int DEFAULT_DATA_W = 32;
    localparam int DEFAULT_DEPTH  = 4;
    localparam int MIN_DEPTH      = 2;

    // Occupancy must be able to represent 0..DEPTH inclusive.
    function automatic int level_width(input int depth);
        return $clog2(depth + 1);
    endfunction

    function automatic bit is_pow2(input int value);
        return (value > 0) && ((value & (value - 1)) == 0);
    endfunction

endpackage

// File: rtl/master_if_fifo.sv
// DEPTH x DATA_W register FIFO with registered non-empty flag and synchronous flush.
module master_if_fifo
    import master_if_pkg::*;
#(
    parameter int DATA_W = DEFAULT_DATA_W,
    parameter int DEPTH  = DEFAULT_DEPTH,
    parameter int LVL_W  = level_width(DEPTH)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              push,
    input  logic [DATA_W-1:0] push_data,
    input  logic              pop,
    input  logic              flush,
    output logic [DATA_W-1:0] head_data,
    output logic              head_valid,
    output logic [LVL_W-1:0]  level
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [DATA_W-1:0] mem [DEPTH];
    logic [PTR_W-1:0]  wr_ptr;
    logic [PTR_W-1:0]  rd_ptr;
    logic [LVL_W-1:0]  level_next;
    logic              do_push;
    logic              do_pop;

    assign do_push = push & ~flush;
    assign do_pop  = pop & head_valid & ~flush;

    // NOTE: level_next gets its default before the case so no path leaves it unassigned (no latch).
    always_comb begin
        level_next = level;
        if (flush) begin
            level_next = '0;
        end else begin
            unique case ({do_push, do_pop})
                2'b10:   level_next = level + 1'b1;
                2'b01:   level_next = level - 1'b1;
                default: level_next = level;
            endcase
        end
    end

    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            level      <= '0;
            head_valid <= 1'b0;
        end else begin
            level      <= level_next;
            head_valid <= (level_next != '0);
            if (flush) begin
                wr_ptr <= '0;
                rd_ptr <= '0;
            end else begin
                // Power-of-two depth: pointers wrap by natural overflow.
                if (do_push) wr_ptr <= wr_ptr + 1'b1;
                if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
            end
        end
    end

    // NOTE: storage is deliberately not reset; validity is tracked by level/head_valid alone.
    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= push_data;
    end

    // Stale storage never leaks out: data reads as zero whenever nothing is valid.
    assign head_data = head_valid ? mem[rd_ptr] : '0;

endmodule

// File: rtl/master_interface_pf.sv
// Master-side bridge: req/busy upstream puller with prefetch FIFO feeding a valid/ready slave link.
module master_interface_pf
    import master_if_pkg::*;
#(
    parameter int DATA_W = DEFAULT_DATA_W,
    parameter int DEPTH  = DEFAULT_DEPTH,
    parameter int LVL_W  = level_width(DEPTH)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              i_enable,
    input  logic              i_flush,
    input  logic [DATA_W-1:0] i_master_data,
    input  logic              i_master_busy,
    output logic              o_master_req,
    output logic [DATA_W-1:0] o_master_data,
    output logic              o_master_valid,
    input  logic              i_master_ready,
    output logic [LVL_W-1:0]  o_level
);

    if (DEPTH < MIN_DEPTH || !is_pow2(DEPTH)) begin : g_bad_depth
        $error("master_interface_pf: DEPTH must be a power of two and at least MIN_DEPTH");
    end

    localparam logic [LVL_W:0] DEPTH_L = (LVL_W + 1)'(DEPTH);

    logic           armed;
    logic           inflight;
    logic           accept;
    logic           shake;
    logic [LVL_W:0] committed;

    // Credit counts both buffered words and the one still on its way from upstream.
    assign committed    = {1'b0, o_level} + {{LVL_W{1'b0}}, inflight};
    // armed keeps req low while reset is held, independent of i_enable.
    assign o_master_req = armed & i_enable & ~i_flush & (committed < DEPTH_L);
    assign accept       = o_master_req & ~i_master_busy;
    assign shake        = o_master_valid & i_master_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            armed    <= 1'b0;
            inflight <= 1'b0;
        end else begin
            armed    <= 1'b1;
            inflight <= accept;
        end
    end

    master_if_fifo #(
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH),
        .LVL_W  (LVL_W)
    ) u_fifo (
        .clk        (clk),
        .rst_n      (rst_n),
        .push       (inflight),
        .push_data  (i_master_data),
        .pop        (shake),
        .flush      (i_flush),
        .head_data  (o_master_data),
        .head_valid (o_master_valid),
        .level      (o_level)
    );

endmodule

// File: tb/tb_master_interface_pf.sv
// Randomised and directed bench for master_interface_pf (DEPTH=4 and DEPTH=2 instances) against a queue model.
module tb_master_interface_pf;

    localparam int DW = 32;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          sel = 1'b0;
    logic          enable = 1'b0, flush = 1'b0, busy = 1'b0, ready = 1'b0;
    logic [DW-1:0] mdata = '0;

    logic          req_a, valid_a, req_b, valid_b;
    logic [DW-1:0] data_a, data_b;
    logic [2:0]    level_a;
    logic [1:0]    level_b;

    always #5 clk = ~clk;

    master_interface_pf #(.DATA_W(DW), .DEPTH(4)) dut_a (
        .clk(clk), .rst_n(rst_n),
        .i_enable(enable & ~sel), .i_flush(flush & ~sel),
        .i_master_data(mdata), .i_master_busy(busy | sel),
        .o_master_req(req_a), .o_master_data(data_a), .o_master_valid(valid_a),
        .i_master_ready(ready & ~sel), .o_level(level_a)
    );

    master_interface_pf #(.DATA_W(DW), .DEPTH(2)) dut_b (
        .clk(clk), .rst_n(rst_n),
        .i_enable(enable & sel), .i_flush(flush & sel),
        .i_master_data(mdata), .i_master_busy(busy | ~sel),
        .o_master_req(req_b), .o_master_data(data_b), .o_master_valid(valid_b),
        .i_master_ready(ready & sel), .o_level(level_b)
    );

    int total = 0;
    int bad = 0;

    // Reference model: buffered words, the word expected from upstream, and a source counter.
    int            depth = 4;
    logic [DW-1:0] q[$];
    bit            pend = 0;
    logic [DW-1:0] pend_word = '0;
    bit            armed_m = 0;
    logic [DW-1:0] src_cnt = 32'd1;
    int            model_shakes = 0;

    int            cyc = 0;
    logic          last_req, last_valid;
    int            last_level;
    logic [DW-1:0] obs_deliv[$];
    int            obs_cyc[$];
    int            obs_shakes = 0;

    task automatic check(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=0x%08h expected=0x%08h (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    task automatic read_outputs(output logic r, output logic v, output logic [DW-1:0] d, output int l);
        r = sel ? req_b : req_a;
        v = sel ? valid_b : valid_a;
        d = sel ? data_b : data_a;
        l = sel ? int'(level_b) : int'(level_a);
    endtask

    task automatic model_reset();
        q.delete();
        pend    = 0;
        armed_m = 0;
    endtask

    // One clock cycle, entered and left at a falling edge.
    task automatic step(input bit en, input bit fl, input bit bz, input bit rd);
        logic          exp_req, exp_valid, o_req, o_valid;
        logic [DW-1:0] exp_data, o_data;
        int            exp_level, o_level;
        enable = en; flush = fl; busy = bz; ready = rd;
        mdata  = pend ? pend_word : DW'($urandom());
        exp_level = q.size();
        exp_valid = (exp_level != 0);
        exp_data  = exp_valid ? q[0] : '0;
        exp_req   = armed_m && en && !fl && (exp_level + int'(pend) < depth);
        #1;
        read_outputs(o_req, o_valid, o_data, o_level);
        check("req", o_req, exp_req);
        check("valid", o_valid, exp_valid);
        check("level", o_level, exp_level);
        check("level_bound", o_level <= depth, 1'b1);
        if (exp_valid) check("data", o_data, exp_data);
        last_req = o_req; last_valid = o_valid; last_level = o_level;
        if (o_valid && rd) begin
            obs_deliv.push_back(o_data);
            obs_cyc.push_back(cyc);
            obs_shakes++;
        end
        @(posedge clk);
        if (exp_valid && rd) begin
            void'(q.pop_front());
            model_shakes++;
        end
        if (pend && !fl) q.push_back(pend_word);
        if (fl) q.delete();
        pend = exp_req && !bz;
        if (pend) begin
            pend_word = src_cnt;
            src_cnt   = src_cnt + 1;
        end
        armed_m = 1;
        cyc++;
        @(negedge clk);
    endtask

    task automatic reset_and_check();
        logic          o_req, o_valid;
        logic [DW-1:0] o_data;
        int            o_level;
        @(negedge clk);
        enable = 0; flush = 0; busy = 0; ready = 0;
        rst_n = 1'b0;
        model_reset();
        @(negedge clk);
        read_outputs(o_req, o_valid, o_data, o_level);
        check("rst_req", o_req, 1'b0);
        check("rst_valid", o_valid, 1'b0);
        check("rst_data", o_data, '0);
        check("rst_level", o_level, 0);
        rst_n = 1'b1;
    endtask

    initial begin
        int first_req, first_valid, guard;
        logic          o_req, o_valid;
        logic [DW-1:0] o_data;
        int            o_level;

        // Streaming, DEPTH=4
        reset_and_check();
        src_cnt = 32'd1;
        obs_deliv.delete(); obs_cyc.delete();
        first_req = -1; first_valid = -1;
        for (int i = 0; i < 40; i++) begin
            step(1, 0, 0, 1);
            if (first_req < 0 && last_req) first_req = i;
            if (first_valid < 0 && last_valid) first_valid = i;
        end
        check("first_valid_latency", first_valid - first_req, 2);
        check("stream_count_ge_32", obs_deliv.size() >= 32, 1'b1);
        if (obs_deliv.size() >= 32) begin
            for (int k = 0; k < 32; k++) begin
                check("stream_word", obs_deliv[k], DW'(k + 1));
                check("stream_back_to_back", obs_cyc[k], obs_cyc[0] + k);
            end
        end
        check("stream_level_settles", last_level, 1);

        // Backpressure
        for (int i = 0; i < 10; i++) step(1, 0, 0, 0);
        check("bp_level_full", last_level, 4);
        check("bp_req_low", last_req, 1'b0);
        for (int i = 0; i < 12; i++) step(1, 0, 0, 1);

        // Busy on alternate cycles
        for (int i = 0; i < 30; i++) step(1, 0, i[0], 1);

        // Flush with three buffered words and one in flight
        for (int i = 0; i < 8; i++) step(0, 0, 0, 1);
        guard = 0;
        while (!(q.size() == 3 && pend) && guard < 12) begin
            step(1, 0, 0, 0);
            guard++;
        end
        check("flush_setup_reached", guard < 12, 1'b1);
        step(1, 1, 0, 0);
        check("flush_level_cleared", q.size(), 0);
        step(1, 0, 0, 1);
        check("flush_valid_low", last_valid, 1'b0);
        check("flush_level_zero", last_level, 0);
        for (int i = 0; i < 10; i++) step(1, 0, 0, 1);

        // Randomised traffic with occasional flushes and enable drops
        for (int i = 0; i < 400; i++)
            step($urandom_range(0, 9) != 0, $urandom_range(0, 24) == 0,
                 $urandom_range(0, 9) < 3, $urandom_range(0, 9) < 7);

        // Async reset mid-stream while valid is high
        for (int i = 0; i < 6; i++) step(1, 0, 0, 1);
        check("pre_reset_valid", last_valid, 1'b1);
        #2 rst_n = 1'b0;
        #1;
        read_outputs(o_req, o_valid, o_data, o_level);
        check("async_rst_req", o_req, 1'b0);
        check("async_rst_valid", o_valid, 1'b0);
        check("async_rst_level", o_level, 0);
        model_reset();
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 20; i++) step(1, 0, 0, 1);

        // DEPTH=2 instance with the same streaming stimulus
        sel = 1'b1;
        depth = 2;
        reset_and_check();
        model_shakes = 0; obs_shakes = 0;
        for (int i = 0; i < 40; i++) step(1, 0, 0, 1);
        check("d2_shake_count", obs_shakes, model_shakes);
        for (int i = 0; i < 200; i++)
            step($urandom_range(0, 9) != 0, $urandom_range(0, 29) == 0,
                 $urandom_range(0, 9) < 3, $urandom_range(0, 9) < 7);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
